pipe_ctrl: RTL

Pipeline sequencing controller for the five-stage core. It collects stall requests from decode (load-use) and execute (multi-cycle ALU ops), and drives a per-stage stall vector into pc_reg, if_id, id_ex, ex_mem and mem_wb. It also serialises exception flushes and redirects the PC, and guards against hung execute stalls with a watchdog. It keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges decode/execute stall requests into a
// per-stage stall vector, serialises exception flushes and runs a stall watchdog.
module pipe_ctrl #(
    parameter int unsigned STALL_TIMEOUT = 64,
    parameter logic [31:0] TIMEOUT_VEC   = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        excp_i,
    input  logic [31:0] excp_pc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [1:0]  state_o,
    output logic        timeout_o,
    output logic [31:0] stall_cycles_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam logic [15:0] WD_LAST   = 16'(STALL_TIMEOUT - 1);
    localparam logic [5:0]  STALL_EX  = 6'b001111;
    localparam logic [5:0]  STALL_ID  = 6'b000111;

    state_e      state_q;
    state_e      state_d;
    logic [15:0] wd_cnt;
    logic        in_flush;
    logic        wd_fire;

    assign in_flush = (state_q == FLUSH);

    // An exception in the firing cycle wins, so the watchdog stays quiet then.
    assign wd_fire = stallreq_ex_i && !excp_i && !in_flush && (wd_cnt == WD_LAST);

    // Stall vector is combinational so a request stalls in the cycle it is raised.
    always_comb begin
        stall_o = 6'b000000;
        if (rst || in_flush || excp_i)
            stall_o = 6'b000000;
        else if (stallreq_ex_i)
            stall_o = STALL_EX;
        else if (stallreq_id_i)
            stall_o = STALL_ID;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = RUN;
        if (excp_i)
            state_d = FLUSH;
        else if (in_flush)
            state_d = RUN;
        else if (wd_fire)
            state_d = FLUSH;
        else if (stallreq_ex_i || stallreq_id_i)
            state_d = STALL;
    end

    always_comb begin
        state_o = state_q;
        flush_o = in_flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt         <= 16'd0;
            new_pc_o       <= 32'h0;
            timeout_o      <= 1'b0;
            stall_cycles_o <= 32'h0;
        end else begin
            if (excp_i || in_flush || !stallreq_ex_i || wd_fire)
                wd_cnt <= 16'd0;
            else
                wd_cnt <= wd_cnt + 16'd1;

            if (excp_i)
                new_pc_o <= excp_pc_i;
            else if (wd_fire)
                new_pc_o <= TIMEOUT_VEC;

            if (wd_fire)
                timeout_o <= 1'b1;

            if ((stall_o != 6'b000000) && (stall_cycles_o != 32'hFFFF_FFFF))
                stall_cycles_o <= stall_cycles_o + 32'd1;
        end
    end

endmodule
